ddr_luma_line_fetcher: RTL
==========================

// Module: ddr_luma_line_fetcher
// PURPOSE
//  Fetches one Y (luma) line of a decoded FMV frame from DDR and streams it, 64 bits at a time,
//  into the luma line buffer's write port (8 pixels per word, pixel 0 in bits [7:0]).
//  Sits between the DDR read arbiter port and the line buffer; the display side triggers one fetch
//  per line.
//  Issues burst reads with one burst outstanding at a time and reports completion.
// PARAMETERS
//  ADDR_W     29   DDR address width, in 64-bit word units
//  MAX_BURST  16   maximum beats per DDR read burst (1..255)
//  MAX_PIXELS 640  line width clamp in pixels; the line buffer depth is MAX_PIXELS/8 words
// PORTS
//  clk_in            in   1       DDR-side clock; all logic is on the rising edge
//  reset             in   1       synchronous, active-high
//  line_start        in   1       one-cycle request to fetch a line; ignored while busy=1
//  line_base         in   ADDR_W  64-bit word address of pixel 0; sampled with line_start
//  line_width        in   10      line width in pixels; sampled with line_start
//  busy              out  1       fetch in progress
//  done              out  1       one-cycle pulse when the last word has been written to the buffer
//  ddr_address       out  ADDR_W  burst start address
//  ddr_burstcnt      out  8       beats in the current burst
//  ddr_read          out  1       read request; held until accepted
//  ddr_waitrequest   in   1       request is accepted on a cycle with ddr_read=1 and waitrequest=0
//  ddr_readdata      in   64      read beat data
//  ddr_readdatavalid in   1       read beat valid
//  lb_reset          out  1       one-cycle pulse; clears the line buffer write pointer
//  lb_wdata          out  64      word to the line buffer
//  lb_we             out  1       line buffer write enable
// BEHAVIOUR
//  Reset values: busy=0, done=0, ddr_read=0, ddr_address=0, ddr_burstcnt=0, lb_reset=0,
//   lb_we=0, lb_wdata=0; state=IDLE.
//  Word count: words = ceil(min(line_width, MAX_PIXELS)/8); 11-bit arithmetic, no overflow.
//  States:
//   IDLE: on line_start, latch base and words, pulse lb_reset, set busy.
//    words==0 -> DONE; otherwise -> REQ.
//   REQ: ddr_read=1, ddr_address=next_addr, ddr_burstcnt=min(MAX_BURST, words_left_to_request).
//    Address and burstcnt stay stable while waitrequest=1.
//    On acceptance: ddr_read=0 the next cycle, next_addr += burstcnt, -> WAIT_DATA.
//   WAIT_DATA: count beats of the current burst.
//    After the last beat: if words remain to request -> REQ; else -> DONE.
//   DONE: done=1 for one cycle, busy=0 the next cycle, -> IDLE.
//    A line_start on that next cycle is accepted.
//  Data path: each beat with readdatavalid=1 during WAIT_DATA produces lb_we=1 and
//   lb_wdata=readdata one cycle later (registered, fixed 1-cycle latency).
//  Data order is unchanged; beats are never reordered or merged.
//  Timing: the done pulse is the cycle after the final lb_we. Exactly `words` lb_we pulses
//   occur per line.
//  lb_reset is asserted in the first busy cycle, which is always before the first lb_we.
//  readdatavalid in IDLE/REQ/DONE (stray or post-reset beats) is discarded: no lb_we, counters
//   unchanged.
//  The first REQ cycle follows lb_reset by one cycle.
//  line_start while busy=1 is ignored; the latched base and width are unaffected.
//  Reset mid-fetch: all outputs return to reset values on the next cycle.
//   The beats still in flight are dropped because of the IDLE discard rule.
//   The DDR side must not be re-requested until it drains; the arbiter ensures this.
//  Addresses wrap modulo 2^ADDR_W; no boundary splitting is performed.
// TESTING
//  1) base=0x1000, width=384, zero-wait DDR -> 3 bursts (0x1000/16, 0x1010/16, 0x1020/16);
//     48 lb_we in order; done once.
//  2) width=528 -> bursts of 16,16,16,16,2 at base+0/16/32/48/64; 66 lb_we.
//  3) width=3 -> one burst, burstcnt=1; width=0 -> no ddr_read, lb_reset then done 2 cycles later.
//  4) waitrequest held 5 cycles on the 2nd burst -> ddr_address and burstcnt stable for all 5;
//     exactly one accept.
//  5) width=1000 -> clamped to 80 words (5 bursts). line_start pulsed mid-fetch -> ignored.
//  6) reset asserted after 7 beats of the 1st burst -> idle next cycle; the remaining 9 beats
//     give no lb_we; a new fetch then completes normally.

Source files
------------

// File: rtl/ddr_luma_line_fetcher.sv
// ddr_luma_line_fetcher
// Fetches one luma line from DDR in bursts (one outstanding) and streams the
// 64-bit beats into the luma line buffer write port with a fixed 1-cycle delay.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for line_start; stray read beats are discarded
// INIT      | first busy cycle; lb_reset pulse, first burst length computed
// REQ       | ddr_read held with stable address/burstcnt until accepted
// WAIT_DATA | counting beats of the outstanding burst
// FLUSH     | last buffer write in progress (or empty line)
// DONE      | done pulse; busy drops the following cycle
module ddr_luma_line_fetcher #(
  parameter int ADDR_W     = 29,
  parameter int MAX_BURST  = 16,
  parameter int MAX_PIXELS = 640
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_base,
  input  logic [9:0]        line_width,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ddr_address,
  output logic [7:0]        ddr_burstcnt,
  output logic              ddr_read,
  input  logic              ddr_waitrequest,
  input  logic [63:0]       ddr_readdata,
  input  logic              ddr_readdatavalid,
  output logic              lb_reset,
  output logic [63:0]       lb_wdata,
  output logic              lb_we
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_REQ,
    S_WAIT_DATA,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [10:0] MAX_PIX_W   = 11'(MAX_PIXELS);
  localparam logic [10:0] MAX_BURST_W = 11'(MAX_BURST);
  localparam logic [7:0]  MAX_BURST_B = 8'(MAX_BURST);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] next_addr;
  logic [10:0]       words_left;
  logic [7:0]        burst;
  logic [7:0]        beats_left;
  logic [10:0]       width_clamped;
  logic [10:0]       words_in;
  logic [7:0]        burst_calc;
  logic              accept;
  logic              beat;
  logic              last_beat;

  // Word count from the clamped width, and length of the next burst to issue.
  always_comb begin
    width_clamped = ({1'b0, line_width} > MAX_PIX_W) ? MAX_PIX_W : {1'b0, line_width};
    words_in      = (width_clamped + 11'd7) >> 3;
    burst_calc    = (words_left > MAX_BURST_W) ? MAX_BURST_B : words_left[7:0];
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    lb_reset   = 1'b0;
    ddr_read   = 1'b0;
    accept     = 1'b0;
    beat       = 1'b0;
    last_beat  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (line_start) state_next = S_INIT;
      end
      S_INIT: begin
        lb_reset   = 1'b1;
        state_next = (words_left == 11'd0) ? S_FLUSH : S_REQ;
      end
      S_REQ: begin
        ddr_read = 1'b1;
        if (!ddr_waitrequest) begin
          accept     = 1'b1;
          state_next = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        beat      = ddr_readdatavalid;
        last_beat = ddr_readdatavalid && (beats_left == 8'd1);
        if (last_beat) state_next = (words_left == 11'd0) ? S_FLUSH : S_REQ;
      end
      S_FLUSH: state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Request bookkeeping: latched line parameters, burst address/length, beat counter.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      next_addr  <= '0;
      words_left <= '0;
      burst      <= '0;
      beats_left <= '0;
    end else begin
      if (state == S_IDLE && line_start) begin
        next_addr  <= line_base;
        words_left <= words_in;
      end
      if (state_next == S_REQ && state != S_REQ) burst <= burst_calc;
      if (accept) begin
        next_addr  <= next_addr + ADDR_W'(burst);
        words_left <= words_left - 11'(burst);
        beats_left <= burst;
      end
      if (beat) beats_left <= beats_left - 8'd1;
    end
  end

  // Registered write port: one buffer write per accepted beat, one cycle later.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      lb_we    <= 1'b0;
      lb_wdata <= '0;
    end else begin
      lb_we <= beat;
      if (beat) lb_wdata <= ddr_readdata;
    end
  end

  // The burst address/length registers only change outside REQ, so they are
  // stable for the whole time a request waits for acceptance.
  assign ddr_address  = next_addr;
  assign ddr_burstcnt = burst;

endmodule
